// File: rtl/br_predict_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_predict_pkg
// Description : Branch control codes and helpers shared by the predictor.
// Revision    : 1.0
// ============================================================================
package br_predict_pkg;

    localparam logic [3:0] c_br_none = 4'h0;
    localparam logic [3:0] c_br_beq  = 4'h1;
    localparam logic [3:0] c_br_bne  = 4'h2;
    localparam logic [3:0] c_br_j    = 4'h3;

    typedef enum logic [1:0] {
        CB_NONE = 2'd0,
        CB_BEQ  = 2'd1,
        CB_BNE  = 2'd2,
        CB_J    = 2'd3
    } cb_kind_e;

    // Anything not recognised behaves as a non-branch instruction.
    function automatic cb_kind_e decode_cb(input logic [3:0] cb);
        case (cb)
            c_br_beq: return CB_BEQ;
            c_br_bne: return CB_BNE;
            c_br_j:   return CB_J;
            default:  return CB_NONE;
        endcase
    endfunction

    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_resolve.sv
`default_nettype none
// ============================================================================
// Module      : br_resolve
// Description : Combinational EX-stage branch/jump resolution.
// Revision    : 1.0
// ============================================================================
module br_resolve
    import br_predict_pkg::*;
(
    input  logic [31:0] i_ex_pc,
    input  logic [3:0]  i_ex_cb,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    input  logic [15:0] i_offset,
    input  logic [25:0] i_instr_index,
    output logic        o_is_branch,
    output logic        o_is_jump,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic [31:0] o_next_pc
);

    cb_kind_e    w_kind;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    always_comb begin
        w_kind      = decode_cb(i_ex_cb);
        w_pc_plus4  = i_ex_pc + 32'd4;
        w_br_target = w_pc_plus4 + {{14{i_offset[15]}}, i_offset, 2'b00};
        w_j_target  = {i_ex_pc[31:28], i_instr_index, 2'b00};

        o_is_branch = (w_kind != CB_NONE);
        o_is_jump   = (w_kind == CB_J);
        o_target    = o_is_jump ? w_j_target : w_br_target;

        o_taken = 1'b0;
        case (w_kind)
            CB_BEQ:  o_taken = (i_rd1 == i_rd2);
            CB_BNE:  o_taken = (i_rd1 != i_rd2);
            CB_J:    o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase

        o_next_pc = o_taken ? o_target : w_pc_plus4;
    end

endmodule
`default_nettype wire

// File: rtl/br_predict.sv
`default_nettype none
// ============================================================================
// Module      : br_predict
// Description : Direct-mapped tagged branch predictor with 2-bit counters,
//               EX-stage training, mispredict redirect and statistics.
// Revision    : 1.0
// ============================================================================
module br_predict
    import br_predict_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_cb,
    input  logic [31:0] ex_rd1,
    input  logic [31:0] ex_rd2,
    input  logic [15:0] ex_offset,
    input  logic [25:0] ex_instr_index,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid   [ENTRIES];
    logic [TAG_W-1:0] r_tag     [ENTRIES];
    logic             r_is_jump [ENTRIES];
    logic [31:0]      r_target  [ENTRIES];
    logic [1:0]       r_cnt     [ENTRIES];

    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_br_cnt;
    logic [31:0] r_miss_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_is_branch;
    logic             w_is_jump;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_next_pc;
    logic             w_mispredict;
    logic             w_alloc;
    logic             w_train;
    logic             w_inval;
    logic [1:0]       w_cnt_next;

    br_resolve u_resolve (
        .i_ex_pc       (ex_pc),
        .i_ex_cb       (ex_cb),
        .i_rd1         (ex_rd1),
        .i_rd2         (ex_rd2),
        .i_offset      (ex_offset),
        .i_instr_index (ex_instr_index),
        .o_is_branch   (w_is_branch),
        .o_is_jump     (w_is_jump),
        .o_taken       (w_taken),
        .o_target      (w_target),
        .o_next_pc     (w_next_pc)
    );

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign w_f_idx     = f_pc[IDX_W+1:2];
    assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == f_pc[31:IDX_W+2]);
    assign pred_taken  = w_f_hit && (r_is_jump[w_f_idx] || r_cnt[w_f_idx][1]);
    assign pred_target = pred_taken ? r_target[w_f_idx] : f_pc + 32'd4;

    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    assign w_ex_tag     = ex_pc[31:IDX_W+2];
    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_mispredict = ex_valid &&
                          ((w_taken != ex_pred_taken) ||
                           (w_taken && (w_target != ex_pred_target)));

    assign w_alloc    = ex_valid && w_is_branch && !w_ex_hit && w_taken;
    assign w_train    = ex_valid && w_is_branch && w_ex_hit;
    assign w_inval    = ex_valid && !w_is_branch && w_ex_hit;
    assign w_cnt_next = w_alloc ? 2'b10 : cnt_step(r_cnt[w_ex_idx], w_taken);

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[e] <= 1'b0;
                r_cnt[e]   <= CNT_INIT;
            end else if (w_ex_idx == IDX_W'(e)) begin
                if (w_alloc || w_train) begin
                    r_valid[e]   <= 1'b1;
                    r_tag[e]     <= w_ex_tag;
                    r_is_jump[e] <= w_is_jump;
                    r_target[e]  <= w_target;
                    r_cnt[e]     <= w_cnt_next;
                end else if (w_inval) begin
                    r_valid[e] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_br_cnt      <= 32'd0;
            r_miss_cnt    <= 32'd0;
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict)
                r_redirect_pc <= w_next_pc;
            if (ex_valid && w_is_branch && (r_br_cnt != 32'hFFFF_FFFF))
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign br_cnt      = r_br_cnt;
    assign miss_cnt    = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_br_predict.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_predict
// Description : Directed + randomized bench for br_predict against a table model.
// Revision    : 1.0
// ============================================================================
module tb_br_predict;
    import br_predict_pkg::*;

    localparam int ENT = 4;
    localparam int IDX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_cb;
    logic [31:0] ex_rd1, ex_rd2;
    logic [15:0] ex_offset;
    logic [25:0] ex_instr_index;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int n_pass  = 0;
    int n_total = 0;

    br_predict #(.ENTRIES(ENT), .CNT_INIT(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .f_pc           (f_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_cb          (ex_cb),
        .ex_rd1         (ex_rd1),
        .ex_rd2         (ex_rd2),
        .ex_offset      (ex_offset),
        .ex_instr_index (ex_instr_index),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  [ENT];
    longint      m_tag    [ENT];
    bit          m_jump   [ENT];
    logic [31:0] m_target [ENT];
    int          m_cnt    [ENT];
    bit          m_ready = 0;
    bit          m_redirect;
    logic [31:0] m_redirect_pc;
    longint      m_br, m_miss;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc / (4 * ENT));
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int i = idx_of(pc);
        bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk = hit && (m_jump[i] || m_cnt[i] >= 2);
        tg = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] res_target(input logic [31:0] pc, input logic [3:0] cb,
                                               input logic [15:0] off, input logic [25:0] ix);
        if (cb == c_br_j) return (pc & 32'hF000_0000) | (32'(ix) * 32'd4);
        return pc + 32'd4 + 32'(int'($signed(off)) * 4);
    endfunction

    always @(posedge clk) begin : model
        bit          is_br, tk, mis, hit;
        logic [31:0] tgt, nxt;
        int          i;
        if (rst) begin
            for (int k = 0; k < ENT; k++) begin
                m_valid[k] = 0;
                m_cnt[k]   = 1;
            end
            m_redirect    = 0;
            m_redirect_pc = 0;
            m_br          = 0;
            m_miss        = 0;
            m_ready       = 1;
        end else if (m_ready) begin
            m_redirect = 0;
            if (ex_valid) begin
                is_br = (ex_cb == c_br_beq) || (ex_cb == c_br_bne) || (ex_cb == c_br_j);
                tk = (ex_cb == c_br_j) || (ex_cb == c_br_beq && ex_rd1 == ex_rd2) ||
                     (ex_cb == c_br_bne && ex_rd1 != ex_rd2);
                tgt = res_target(ex_pc, ex_cb, ex_offset, ex_instr_index);
                nxt = tk ? tgt : ex_pc + 32'd4;
                mis = (tk != ex_pred_taken) || (tk && tgt != ex_pred_target);
                i   = idx_of(ex_pc);
                hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
                if (is_br) begin
                    if (hit) begin
                        m_cnt[i]    = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                        m_target[i] = tgt;
                        m_jump[i]   = (ex_cb == c_br_j);
                    end else if (tk) begin
                        m_valid[i]  = 1;
                        m_tag[i]    = tag_of(ex_pc);
                        m_jump[i]   = (ex_cb == c_br_j);
                        m_target[i] = tgt;
                        m_cnt[i]    = 2;
                    end
                    if (m_br < 64'hFFFF_FFFF) m_br++;
                end else if (hit) begin
                    m_valid[i] = 0;
                end
                if (mis) begin
                    m_redirect    = 1;
                    m_redirect_pc = nxt;
                    if (m_miss < 64'hFFFF_FFFF) m_miss++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit          et;
        logic [31:0] etg;
        if (m_ready) begin
            m_lookup(f_pc, et, etg);
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, et});
            chk("pred_target", pred_target, etg);
            chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
            if (m_redirect) chk("redirect_pc", redirect_pc, m_redirect_pc);
            chk("br_cnt", br_cnt, 32'(m_br));
            chk("miss_cnt", miss_cnt, 32'(m_miss));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] cb, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] off, input logic [25:0] ix,
                         input logic pt, input logic [31:0] ptg);
        ex_valid = 1; ex_cb = cb; ex_pc = pc; ex_rd1 = a; ex_rd2 = b;
        ex_offset = off; ex_instr_index = ix; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pool_pc();
        logic [31:0] base = ($urandom_range(0, 1) == 1) ? 32'h0040_0000 : 32'h1000_0000;
        return base + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    initial begin
        bit          lt;
        logic [31:0] ltg;
        rst = 1; f_pc = 0; ex_valid = 0; ex_pc = 0; ex_cb = c_br_none;
        ex_rd1 = 0; ex_rd2 = 0; ex_offset = 0; ex_instr_index = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
        repeat (2) edge1();
        rst = 0; f_pc = 32'h0040_0000;
        @(negedge clk);
        chk("lit_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("lit_rst_pred_target", pred_target, 32'h0040_0004);
        chk("lit_rst_br_cnt", br_cnt, 32'd0);
        chk("lit_rst_miss_cnt", miss_cnt, 32'd0);
        chk("lit_rst_redirect_pc", redirect_pc, 32'd0);

        // taken beq, backward offset
        drive(c_br_beq, 32'h0040_0010, 5, 5, 16'hFFFC, 0, 0, 32'h0040_0014);
        edge1();
        ex_valid = 0; f_pc = 32'h0040_0010;
        @(negedge clk);
        chk("lit_beq_redirect", {31'd0, redirect}, 32'd1);
        chk("lit_beq_redirect_pc", redirect_pc, 32'h0040_0004);
        chk("lit_beq_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("lit_beq_pred_target", pred_target, 32'h0040_0004);

        // counter walks down and saturates at 00
        drive(c_br_beq, 32'h0040_0010, 5, 6, 16'hFFFC, 0, 1, 32'h0040_0004);
        edge1();
        chk("lit_nt1_redirect_pc", redirect_pc, 32'h0040_0014);
        drive(c_br_beq, 32'h0040_0010, 5, 6, 16'hFFFC, 0, 0, 32'h0);
        edge1();
        chk("lit_nt2_redirect", {31'd0, redirect}, 32'd0);
        drive(c_br_beq, 32'h0040_0010, 5, 6, 16'hFFFC, 0, 0, 32'h0);
        edge1();
        drive(c_br_beq, 32'h0040_0010, 7, 7, 16'hFFFC, 0, 0, 32'h0);
        edge1();
        ex_valid = 0;
        @(negedge clk);
        chk("lit_sat_pred_taken", {31'd0, pred_taken}, 32'd0);

        // jump
        drive(c_br_j, 32'h1000_0020, 0, 0, 0, 26'h0000100, 0, 0);
        edge1();
        ex_valid = 0; f_pc = 32'h1000_0020;
        @(negedge clk);
        chk("lit_j_redirect_pc", redirect_pc, 32'h1000_0400);
        chk("lit_j_pred_target", pred_target, 32'h1000_0400);

        // aliasing: 0x10 and 0x50 share an index
        drive(c_br_beq, 32'h0000_0050, 1, 1, 16'h0004, 0, 0, 0);
        edge1();
        ex_valid = 0; f_pc = 32'h0000_0010;
        @(negedge clk);
        chk("lit_alias_miss_target", pred_target, 32'h0000_0014);
        f_pc = 32'h0000_0050;
        #1;
        chk("lit_alias_hit_target", pred_target, 32'h0000_0064);
        drive(c_br_none, 32'h0000_0050, 0, 0, 0, 0, 1, 32'h0000_0064);
        edge1();
        ex_valid = 0;
        @(negedge clk);
        chk("lit_none_redirect_pc", redirect_pc, 32'h0000_0054);
        chk("lit_none_pred_target", pred_target, 32'h0000_0054);

        // mispredict coinciding with reset is dropped
        drive(c_br_beq, 32'h0040_0010, 1, 1, 16'h0010, 0, 0, 0);
        rst = 1;
        edge1();
        rst = 0; ex_valid = 0;
        chk("lit_rstmis_redirect", {31'd0, redirect}, 32'd0);
        chk("lit_rstmis_miss_cnt", miss_cnt, 32'd0);
        edge1();
        chk("lit_rstmis_redirect2", {31'd0, redirect}, 32'd0);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            edge1();
            rst      = ($urandom_range(0, 99) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_pc    = pool_pc();
            f_pc     = pool_pc();
            ex_cb    = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3))
                                                   : 4'($urandom_range(0, 15));
            ex_rd1         = 32'($urandom_range(0, 1));
            ex_rd2         = 32'($urandom_range(0, 1));
            ex_offset      = 16'($urandom);
            ex_instr_index = 26'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    m_lookup(ex_pc, lt, ltg);
                    ex_pred_taken  = lt;
                    ex_pred_target = ltg;
                end
                1: begin
                    ex_pred_taken  = 1'($urandom_range(0, 1));
                    ex_pred_target = res_target(ex_pc, ex_cb, ex_offset, ex_instr_index);
                end
                default: begin
                    ex_pred_taken  = 1'($urandom_range(0, 1));
                    ex_pred_target = $urandom;
                end
            endcase
        end
        edge1();
        rst = 0; ex_valid = 0;
        repeat (2) edge1();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
